// File: rtl/param_datapath.sv
// param_datapath: N-register, WIDTH-bit datapath with a fetch/decode/execute FSM driving a mux bus.
// Optional macro DATAPATH_CARRY_EN adds carry_flag and turns opcode 111 into adc.
module param_datapath #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 16,
  localparam int REG_SEL_W = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [WIDTH-1:0]     data,
  output logic [ADDR_W-1:0]    addr,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 zero_flag,
  output logic [WIDTH-1:0]     bus_output,
  input  logic [REG_SEL_W-1:0] dbg_sel,
`ifdef DATAPATH_CARRY_EN
  output logic                 carry_flag,
`endif
  output logic [WIDTH-1:0]     dbg_val
);

  localparam int IR_W = 3 + 2 * REG_SEL_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD_IR = 3'd2;
  localparam logic [2:0] S_T1      = 3'd3;
  localparam logic [2:0] S_T2      = 3'd4;
  localparam logic [2:0] S_T3      = 3'd5;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

`ifdef DATAPATH_CARRY_EN
  localparam logic [2:0] OP_ADC = 3'b111;
  localparam int ALU_W = WIDTH + 1;
`else
  localparam int ALU_W = WIDTH;
`endif

  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [IR_W-1:0]      ir_q, ir_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     g_q, g_d;
  logic                 zf_q, zf_d;
  logic [WIDTH-1:0]     dbg_q, dbg_d;
  logic [WIDTH-1:0]     regs_q [NUM_REGS];
  logic [WIDTH-1:0]     regs_d [NUM_REGS];

  logic [2:0]           op;
  logic [REG_SEL_W-1:0] rx, ry;
  logic [WIDTH-1:0]     rx_val, ry_val, bus;
  logic [ALU_W-1:0]     alu_res;
  logic                 is_alu, wr_en, last, bad_op, alu_cin;

`ifdef DATAPATH_CARRY_EN
  logic gc_q, gc_d;
  logic cf_q, cf_d;
  assign alu_cin = cf_q;
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                   (op == OP_XOR) || (op == OP_ADC);
`else
  assign alu_cin = 1'b0;
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
`endif

  // Top bit of the result is carry-out (add/adc) or borrow (sub) when carry support is built in.
  function automatic logic [ALU_W-1:0] alu_op(input logic [2:0] sel, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y, input logic cin);
    logic [WIDTH:0] r;
    case (sel)
      OP_ADD:  r = {1'b0, x} + {1'b0, y};
      OP_SUB:  r = {1'b0, x} - {1'b0, y};
      OP_AND:  r = {1'b0, x & y};
      OP_XOR:  r = {1'b0, x ^ y};
      default: r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    endcase
    return ALU_W'(r);
  endfunction

  assign op = ir_q[IR_W-1 -: 3];
  assign rx = ir_q[IR_W-4 -: REG_SEL_W];
  assign ry = ir_q[REG_SEL_W-1:0];

  always_comb begin
    rx_val = '0;
    ry_val = '0;
    dbg_d  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx == REG_SEL_W'(i)) rx_val = regs_q[i];
      if (ry == REG_SEL_W'(i)) ry_val = regs_q[i];
      if (dbg_sel == REG_SEL_W'(i)) dbg_d = regs_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    zf_d    = zf_q;
    regs_d  = regs_q;
    bus     = '0;
    alu_res = '0;
    wr_en   = 1'b0;
    last    = 1'b0;
    bad_op  = 1'b0;
`ifdef DATAPATH_CARRY_EN
    gc_d = gc_q;
    cf_d = cf_q;
`endif
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_LOAD_IR;
      end
      S_LOAD_IR: begin
        ir_d    = data[WIDTH-1 -: IR_W];
        state_d = S_T1;
      end
      S_T1: begin
        if (op == OP_MV || op == OP_MVNZ) begin
          bus   = ry_val;
          wr_en = (op == OP_MV) || !zf_q;
          last  = 1'b1;
        end else if (op == OP_MVI) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_T2;
        end else if (is_alu) begin
          bus     = rx_val;
          a_d     = bus;
          state_d = S_T2;
        end else begin
          bad_op = 1'b1;
          last   = 1'b1;
        end
      end
      S_T2: begin
        if (op == OP_MVI) begin
          bus   = data;
          wr_en = 1'b1;
          last  = 1'b1;
        end else begin
          bus     = ry_val;
          alu_res = alu_op(op, a_q, bus, alu_cin);
          g_d     = alu_res[WIDTH-1:0];
`ifdef DATAPATH_CARRY_EN
          gc_d = alu_res[WIDTH];
`endif
          state_d = S_T3;
        end
      end
      S_T3: begin
        bus   = g_q;
        wr_en = 1'b1;
        zf_d  = (g_q == '0);
`ifdef DATAPATH_CARRY_EN
        if (op == OP_ADD || op == OP_SUB || op == OP_ADC) cf_d = gc_q;
`endif
        last  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (last) state_d = run ? S_FETCH : S_IDLE;

    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && rx == REG_SEL_W'(i)) regs_d[i] = bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      zf_q    <= 1'b0;
      dbg_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      zf_q    <= zf_d;
      dbg_q   <= dbg_d;
      regs_q  <= regs_d;
    end
  end

`ifdef DATAPATH_CARRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gc_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      gc_q <= gc_d;
      cf_q <= cf_d;
    end
  end

  assign carry_flag = cf_q;
`endif

  assign addr       = pc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = last;
  assign illegal    = bad_op;
  assign zero_flag  = zf_q;
  assign bus_output = bus;
  assign dbg_val    = dbg_q;

endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: vector table of small programs, hand-written corner sequences,
// and random programs checked against an instruction-level model.
module tb_param_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] addr;
  logic        busy, done, illegal, zero_flag;
  logic [15:0] bus_output, dbg_val;
  logic [2:0]  dbg_sel = '0;
`ifdef DATAPATH_CARRY_EN
  logic        carry_flag, carry2;
`endif

  logic        run2 = 1'b0;
  logic [15:0] data2 = '0;
  logic [4:0]  addr2;
  logic        busy2, done2, illegal2, zf2;
  logic [15:0] bus2, dbg_val2;
  logic [2:0]  dbg_sel2 = '0;

  param_datapath dut (
    .clk(clk), .reset(reset), .run(run), .data(data), .addr(addr), .busy(busy),
    .done(done), .illegal(illegal), .zero_flag(zero_flag), .bus_output(bus_output),
    .dbg_sel(dbg_sel),
`ifdef DATAPATH_CARRY_EN
    .carry_flag(carry_flag),
`endif
    .dbg_val(dbg_val)
  );

  param_datapath #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(5)) dut_small (
    .clk(clk), .reset(reset), .run(run2), .data(data2), .addr(addr2), .busy(busy2),
    .done(done2), .illegal(illegal2), .zero_flag(zf2), .bus_output(bus2),
    .dbg_sel(dbg_sel2),
`ifdef DATAPATH_CARRY_EN
    .carry_flag(carry2),
`endif
    .dbg_val(dbg_val2)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  always @(posedge clk) data <= mem[addr];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0][15:0] prog;
    int n, cyc, ill, ra, va, rb, vb, zf, pc, cf;
  } vec_t;
  vec_t vecs [8];

  // Instruction-level reference state
  logic [15:0] m_r [8];
  int m_zf, m_cf, m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int rx, input int ry);
    logic [2:0] o, x, y;
    o = op[2:0]; x = rx[2:0]; y = ry[2:0];
    return {o, x, y, 7'b0};
  endfunction

  function automatic logic [7:0][15:0] pk(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
    return {w7, w6, w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic set_vec(input int i, input logic [7:0][15:0] p, input int n, input int cyc,
                         input int ill, input int ra, input int va, input int rb, input int vb,
                         input int zf, input int pc, input int cf);
    vecs[i].prog = p; vecs[i].n = n; vecs[i].cyc = cyc; vecs[i].ill = ill;
    vecs[i].ra = ra; vecs[i].va = va; vecs[i].rb = rb; vecs[i].vb = vb;
    vecs[i].zf = zf; vecs[i].pc = pc; vecs[i].cf = cf;
  endtask

  task automatic do_reset;
    run = 1'b0;
    run2 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  // Runs n instructions from reset PC, dropping run in the final done cycle.
  task automatic run_prog(input int n, input int budget, output int cyc, output int ill);
    int dn;
    cyc = 0; ill = 0; dn = 0;
    run = 1'b1;
    for (int t = 0; t < budget && dn < n; t++) begin
      @(negedge clk);
      if (busy) cyc++;
      if (illegal) ill++;
      if (done) begin
        dn++;
        if (dn == n) run = 1'b0;
      end
    end
    chk("done_count", dn, n);
    @(negedge clk);
  endtask

  task automatic read_reg(input int i, output logic [15:0] v);
    dbg_sel = i[2:0];
    @(negedge clk);
    v = dbg_val;
  endtask

  task automatic m_run(input int n, output int cyc, output int ill);
    logic [15:0] w;
    int op, rx, ry, a, b, r;
    cyc = 0; ill = 0;
    for (int k = 0; k < n; k++) begin
      w = mem[m_pc];
      m_pc = (m_pc + 1) % 65536;
      op = int'(w[15:13]); rx = int'(w[12:10]); ry = int'(w[9:7]);
      a = int'(m_r[rx]); b = int'(m_r[ry]);
      if (op == 0) begin
        m_r[rx] = m_r[ry]; cyc += 3;
      end else if (op == 1) begin
        m_r[rx] = mem[m_pc]; m_pc = (m_pc + 1) % 65536; cyc += 4;
      end else if (op == 6) begin
        if (m_zf == 0) m_r[rx] = m_r[ry];
        cyc += 3;
`ifndef DATAPATH_CARRY_EN
      end else if (op == 7) begin
        ill++; cyc += 3;
`endif
      end else begin
        case (op)
          2: begin r = a + b; m_cf = (r > 65535) ? 1 : 0; end
          3: begin r = a - b; m_cf = (r < 0) ? 1 : 0; end
          4: r = a & b;
          5: r = a ^ b;
          default: begin r = a + b + m_cf; m_cf = (r > 65535) ? 1 : 0; end
        endcase
        r = (r + 65536) % 65536;
        m_r[rx] = r[15:0];
        m_zf = (r == 0) ? 1 : 0;
        cyc += 5;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ill, ecyc, eill, w, op, sel;
    int prev2, seen;
    logic [15:0] rv, imm;
    logic [15:0] dexp [8];

    for (int i = 0; i < 65536; i++) mem[i] = '0;

    set_vec(0, pk(ins(1,0,0), 16'h0005, ins(1,1,0), 16'h0003, ins(2,0,1), 0, 0, 0),
            3, 13, 0, 0, 'h0008, 1, 'h0003, 0, 5, 0);
    set_vec(1, pk(ins(1,2,0), 16'h0001, ins(1,3,0), 16'h00AA, ins(3,2,2), ins(6,3,2), 0, 0),
            4, 16, 0, 2, 'h0000, 3, 'h00AA, 1, 6, 0);
    set_vec(2, pk(ins(1,3,0), 16'h00AA, ins(1,0,0), 16'h0008, ins(3,2,2), ins(5,2,0), ins(6,3,2), 0),
            5, 21, 0, 2, 'h0008, 3, 'h0008, 0, 7, 0);
    set_vec(3, pk(ins(1,1,0), 16'h0003, ins(3,4,1), 0, 0, 0, 0, 0),
            2, 9, 0, 4, 'hFFFD, 1, 'h0003, 0, 3, 1);
`ifdef DATAPATH_CARRY_EN
    set_vec(4, pk(ins(1,1,0), 16'h0007, ins(7,1,1), ins(0,2,1), 0, 0, 0, 0),
            3, 12, 0, 1, 'h000E, 2, 'h000E, 0, 4, 0);
`else
    set_vec(4, pk(ins(1,1,0), 16'h0007, ins(7,1,1), ins(0,2,1), 0, 0, 0, 0),
            3, 10, 1, 1, 'h0007, 2, 'h0007, 0, 4, 0);
`endif
    set_vec(5, pk(ins(1,1,0), 16'h4001, ins(2,1,1), ins(0,5,1), 0, 0, 0, 0),
            3, 12, 0, 1, 'h8002, 5, 'h8002, 0, 4, 0);
    set_vec(6, pk(ins(1,6,0), 16'hF0F0, ins(1,7,0), 16'h0F0F, ins(4,6,7), 0, 0, 0),
            3, 13, 0, 6, 'h0000, 7, 'h0F0F, 1, 5, 0);
    set_vec(7, pk(ins(1,0,0), 16'hFFFF, ins(1,1,0), 16'h0001, ins(2,0,1), 0, 0, 0),
            3, 13, 0, 0, 'h0000, 1, 'h0001, 1, 5, 1);

    // Reset state, sampled while reset is held
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_addr", addr, 0);
    chk("rst_bus", bus_output, 0);
    chk("rst_dbg", dbg_val, 0);
`ifdef DATAPATH_CARRY_EN
    chk("rst_carry", carry_flag, 0);
`endif

    for (int v = 0; v < 8; v++) begin
      do_reset;
      clear_mem;
      for (int i = 0; i < 8; i++) mem[i] = vecs[v].prog[i];
      run_prog(vecs[v].n, 80, cyc, ill);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
      chk($sformatf("v%0d_illegal", v), ill, vecs[v].ill);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      chk($sformatf("v%0d_pc", v), addr, vecs[v].pc);
      chk($sformatf("v%0d_zero", v), zero_flag, vecs[v].zf);
      chk($sformatf("v%0d_bus_idle", v), bus_output, 0);
`ifdef DATAPATH_CARRY_EN
      chk($sformatf("v%0d_carry", v), carry_flag, vecs[v].cf);
`endif
      read_reg(vecs[v].ra, rv);
      chk($sformatf("v%0d_r%0d", v, vecs[v].ra), rv, vecs[v].va);
      read_reg(vecs[v].rb, rv);
      chk($sformatf("v%0d_r%0d", v, vecs[v].rb), rv, vecs[v].vb);
    end

    // Asynchronous reset in T2 of add R5,R6
    do_reset;
    clear_mem;
    mem[0] = ins(1,6,0); mem[1] = 16'h0009; mem[2] = ins(2,5,6);
    dbg_sel = 3'd6;
    cyc = 0;
    run = 1'b1;
    for (int t = 0; t < 40 && cyc < 8; t++) begin
      @(negedge clk);
      if (busy) cyc++;
    end
    chk("abort_reach_t2", cyc, 8);
    chk("abort_bus_t2", bus_output, 16'h0009);
    chk("abort_dbg_r6", dbg_val, 16'h0009);
    chk("abort_addr_t2", addr, 3);
    reset = 1'b1;
    #1;
    chk("abort_busy_async", busy, 0);
    chk("abort_addr_async", addr, 0);
    chk("abort_bus_async", bus_output, 0);
    chk("abort_done_async", done, 0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_reg(5, rv);
    chk("abort_r5", rv, 0);
    read_reg(6, rv);
    chk("abort_r6_cleared", rv, 0);

    // Debug port sweep: one-cycle latency, no combinational path from dbg_sel
    do_reset;
    clear_mem;
    for (int i = 0; i < 8; i++) begin
      dexp[i] = 16'h1000 + 16'(i * 'h0111);
      mem[2*i] = ins(1, i, 0);
      mem[2*i+1] = dexp[i];
    end
    run_prog(8, 100, cyc, ill);
    chk("sweep_cycles", cyc, 32);
    dbg_sel = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("dbg_r%0d", i), dbg_val, dexp[i]);
      sel = (i + 1) % 8;
      dbg_sel = sel[2:0];
      #1;
      chk($sformatf("dbg_hold_r%0d", i), dbg_val, dexp[i]);
      @(negedge clk);
    end

    // PC wrap on a 5-bit address instance executing mv R0,R0 words
    do_reset;
    prev2 = int'(addr2);
    seen = 0;
    run2 = 1'b1;
    for (int t = 0; t < 400 && seen == 0; t++) begin
      @(negedge clk);
      if (prev2 == 31 && addr2 != 5'd31) begin
        seen = 1;
        chk("pc_wrap", addr2, 0);
      end
      prev2 = int'(addr2);
    end
    chk("pc_wrap_seen", seen, 1);
    run2 = 1'b0;

    // Random programs against the instruction-level model
    for (int p = 0; p < 20; p++) begin
      do_reset;
      clear_mem;
      w = 0;
      for (int k = 0; k < 10; k++) begin
        op = int'($urandom_range(0, 7));
        mem[w] = ins(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        w++;
        if (op == 1) begin
          case ($urandom_range(0, 3))
            0: imm = 16'h0000;
            1: imm = 16'hFFFF;
            default: imm = 16'($urandom);
          endcase
          mem[w] = imm;
          w++;
        end
      end
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_zf = 0; m_cf = 0; m_pc = 0;
      m_run(10, ecyc, eill);
      run_prog(10, 200, cyc, ill);
      chk($sformatf("rnd%0d_cycles", p), cyc, ecyc);
      chk($sformatf("rnd%0d_illegal", p), ill, eill);
      chk($sformatf("rnd%0d_pc", p), addr, m_pc);
      chk($sformatf("rnd%0d_zero", p), zero_flag, m_zf);
`ifdef DATAPATH_CARRY_EN
      chk($sformatf("rnd%0d_carry", p), carry_flag, m_cf);
`endif
      for (int i = 0; i < 8; i++) begin
        read_reg(i, rv);
        chk($sformatf("rnd%0d_r%0d", p, i), rv, m_r[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
